// File: rtl/alarm_trigger.sv
// alarm_trigger: compares running HH:MM against the stored alarm time and
// sequences ringing, snooze, stop and ring timeout.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a fresh enabled time match
// RINGING | buzzer beeping 1 s on / 1 s off, ring timeout running
// SNOOZE  | buzzer silent, snooze timer running before re-ringing
module alarm_trigger #(
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic [1:0] t_hours_left,
  input  logic [3:0] t_hours_right,
  input  logic [2:0] t_minutes_left,
  input  logic [3:0] t_minutes_right,
  input  logic [1:0] a_hours_left,
  input  logic [3:0] a_hours_right,
  input  logic [2:0] a_minutes_left,
  input  logic [3:0] a_minutes_right,
  input  logic       alarm_on,
  input  logic       set_alarm_en,
  input  logic       stop_button,
  input  logic       snooze_button,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozing,
  output logic       missed
);

  localparam int RW = $clog2(RING_TIMEOUT_S + 1);
  localparam int SW = $clog2(SNOOZE_S + 1);
  localparam int NW = $clog2(MAX_SNOOZE + 1);

  localparam logic [RW-1:0] RING_LAST = RW'(RING_TIMEOUT_S - 1);
  localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_S - 1);
  localparam logic [NW-1:0] SNZ_MAX   = NW'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_t;

  state_t        state;
  logic [RW-1:0] ring_cnt;
  logic [SW-1:0] snz_cnt;
  logic [NW-1:0] snooze_cnt;
  logic          beep_phase;
  logic          match_q;

  logic times_equal;
  logic match;
  logic fire;
  logic abort;

  // Match detection and single-shot fire on the rising edge of an enabled match
  always_comb begin
    times_equal = (t_hours_left == a_hours_left) && (t_hours_right == a_hours_right) &&
                  (t_minutes_left == a_minutes_left) && (t_minutes_right == a_minutes_right);
    abort       = ~alarm_on | set_alarm_en;
    match       = ~abort & times_equal;
    fire        = match & ~match_q;
  end

  // Outputs decoded straight from registered state
  always_comb begin
    ringing  = (state == RINGING);
    snoozing = (state == SNOOZE);
    buzzer   = ringing & beep_phase;
  end

  // Alarm sequencer; a button in the same cycle as sec_tick swallows the tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ring_cnt   <= '0;
      snz_cnt    <= '0;
      snooze_cnt <= '0;
      beep_phase <= 1'b1;
      missed     <= 1'b0;
      match_q    <= 1'b0;
    end else begin
      match_q <= match;
      case (state)
        IDLE: begin
          if (fire) begin
            state      <= RINGING;
            ring_cnt   <= '0;
            snooze_cnt <= '0;
            beep_phase <= 1'b1;
            missed     <= 1'b0;
          end else if (stop_button) begin
            missed <= 1'b0;
          end
        end
        RINGING: begin
          if (abort || stop_button) begin
            state <= IDLE;
          end else if (snooze_button) begin
            if (snooze_cnt < SNZ_MAX) begin
              state      <= SNOOZE;
              snooze_cnt <= snooze_cnt + 1'b1;
              snz_cnt    <= '0;
            end
          end else if (sec_tick) begin
            if (ring_cnt == RING_LAST) begin
              state  <= IDLE;
              missed <= 1'b1;
            end else begin
              ring_cnt   <= ring_cnt + 1'b1;
              beep_phase <= ~beep_phase;
            end
          end
        end
        SNOOZE: begin
          if (abort || stop_button) begin
            state <= IDLE;
          end else if (snooze_button) begin
            // snooze is meaningless here; the press is simply dropped
          end else if (sec_tick) begin
            if (snz_cnt == SNZ_LAST) begin
              state      <= RINGING;
              ring_cnt   <= '0;
              beep_phase <= 1'b1;
            end else begin
              snz_cnt <= snz_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_trigger.sv
// Bench for alarm_trigger with short timers. Expected output vectors
// {buzzer, ringing, snoozing, missed} are queued as each cycle is driven and
// compared once the DUT has clocked that cycle.
module tb_alarm_trigger;

  logic       clk;
  logic       rst;
  logic       sec_tick;
  logic [1:0] t_hours_left;
  logic [3:0] t_hours_right;
  logic [2:0] t_minutes_left;
  logic [3:0] t_minutes_right;
  logic [1:0] a_hours_left;
  logic [3:0] a_hours_right;
  logic [2:0] a_minutes_left;
  logic [3:0] a_minutes_right;
  logic       alarm_on;
  logic       set_alarm_en;
  logic       stop_button;
  logic       snooze_button;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic       missed;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string      tag;
    logic [3:0] exp;
  } exp_t;

  exp_t sb[$];

  // {buzzer, ringing, snoozing, missed}
  localparam logic [3:0] O_IDLE = 4'b0000;
  localparam logic [3:0] O_RON  = 4'b1100;
  localparam logic [3:0] O_ROFF = 4'b0100;
  localparam logic [3:0] O_SNZ  = 4'b0010;
  localparam logic [3:0] O_MISS = 4'b0001;

  alarm_trigger #(
    .RING_TIMEOUT_S(5),
    .SNOOZE_S      (3),
    .MAX_SNOOZE    (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sec_tick       (sec_tick),
    .t_hours_left   (t_hours_left),
    .t_hours_right  (t_hours_right),
    .t_minutes_left (t_minutes_left),
    .t_minutes_right(t_minutes_right),
    .a_hours_left   (a_hours_left),
    .a_hours_right  (a_hours_right),
    .a_minutes_left (a_minutes_left),
    .a_minutes_right(a_minutes_right),
    .alarm_on       (alarm_on),
    .set_alarm_en   (set_alarm_en),
    .stop_button    (stop_button),
    .snooze_button  (snooze_button),
    .buzzer         (buzzer),
    .ringing        (ringing),
    .snoozing       (snoozing),
    .missed         (missed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (buz,ring,snz,miss)", tag, act, exp);
    end
  endtask

  task automatic set_time(input int h, input int m);
    t_hours_left    = 2'(h / 10);
    t_hours_right   = 4'(h % 10);
    t_minutes_left  = 3'(m / 10);
    t_minutes_right = 4'(m % 10);
  endtask

  // Clock one cycle with the inputs currently driven, then score it
  task automatic cyc(input string tag, input logic [3:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(e.tag, {buzzer, ringing, snoozing, missed}, e.exp);
    sec_tick      = 1'b0;
    stop_button   = 1'b0;
    snooze_button = 1'b0;
  endtask

  task automatic tick(input string tag, input logic [3:0] exp);
    sec_tick = 1'b1;
    cyc(tag, exp);
  endtask

  // Walk 07:29 -> 07:30 so a fresh match fires
  task automatic arm_and_fire(input string tag);
    set_time(7, 29);
    cyc({tag, "_pre"}, O_IDLE);
    set_time(7, 30);
    cyc({tag, "_fire"}, O_RON);
  endtask

  initial begin
    rst           = 1'b0;
    sec_tick      = 1'b0;
    stop_button   = 1'b0;
    snooze_button = 1'b0;
    alarm_on      = 1'b1;
    set_alarm_en  = 1'b0;
    a_hours_left    = 2'd0;
    a_hours_right   = 4'd7;
    a_minutes_left  = 3'd3;
    a_minutes_right = 4'd0;
    set_time(7, 29);
    repeat (2) @(posedge clk);
    #1;
    chk("reset", {buzzer, ringing, snoozing, missed}, O_IDLE);
    rst = 1'b1;

    // 1: basic ring, beep cadence, stop, no refire while held equal
    arm_and_fire("t1");
    tick("t1_tick1", O_ROFF);
    cyc("t1_gap", O_ROFF);
    tick("t1_tick2", O_RON);
    tick("t1_tick3", O_ROFF);
    stop_button = 1'b1;
    cyc("t1_stop", O_IDLE);
    for (int i = 0; i < 3; i++) cyc("t1_norefire", O_IDLE);

    // 2: timeout sets missed; abort keeps it; stop in IDLE clears it
    arm_and_fire("t2");
    tick("t2_tick1", O_ROFF);
    tick("t2_tick2", O_RON);
    tick("t2_tick3", O_ROFF);
    tick("t2_tick4", O_RON);
    tick("t2_timeout", O_MISS);
    cyc("t2_hold", O_MISS);
    alarm_on = 1'b0;
    cyc("t2_abort_keeps", O_MISS);
    set_time(7, 29);
    alarm_on = 1'b1;
    cyc("t2_rearm", O_MISS);
    stop_button = 1'b1;
    cyc("t2_stop_clr", O_IDLE);

    // 3: snooze cycles up to the limit, then snooze ignored
    arm_and_fire("t3");
    snooze_button = 1'b1;
    cyc("t3_snz1", O_SNZ);
    tick("t3_s1t1", O_SNZ);
    snooze_button = 1'b1;
    cyc("t3_snz_in_snz", O_SNZ);
    tick("t3_s1t2", O_SNZ);
    tick("t3_s1t3", O_RON);
    snooze_button = 1'b1;
    cyc("t3_snz2", O_SNZ);
    tick("t3_s2t1", O_SNZ);
    tick("t3_s2t2", O_SNZ);
    tick("t3_s2t3", O_RON);
    snooze_button = 1'b1;
    cyc("t3_snz3_ignored", O_RON);
    tick("t3_still_ring", O_ROFF);
    stop_button = 1'b1;
    cyc("t3_stop", O_IDLE);

    // 4: stop and snooze together, stop wins
    arm_and_fire("t4");
    stop_button   = 1'b1;
    snooze_button = 1'b1;
    cyc("t4_both", O_IDLE);

    // 5: abort from SNOOZE / RINGING, and no fire while editing
    arm_and_fire("t5");
    snooze_button = 1'b1;
    cyc("t5_snz", O_SNZ);
    set_alarm_en = 1'b1;
    cyc("t5_abort_snz", O_IDLE);
    set_time(7, 29);
    cyc("t5_edit_pre", O_IDLE);
    set_time(7, 30);
    cyc("t5_edit_eq", O_IDLE);
    cyc("t5_edit_eq2", O_IDLE);
    set_alarm_en = 1'b0;
    cyc("t5_edit_done_fire", O_RON);
    alarm_on = 1'b0;
    cyc("t5_abort_ring", O_IDLE);

    // 6: async reset mid-ring; release equal with alarm off stays idle
    alarm_on = 1'b1;
    arm_and_fire("t6");
    rst = 1'b0;
    #1;
    chk("t6_async_rst", {buzzer, ringing, snoozing, missed}, O_IDLE);
    alarm_on = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) cyc("t6_stay_idle", O_IDLE);
    alarm_on = 1'b1;
    cyc("t6_enable_eq_fires", O_RON);

    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
